// File: rtl/vending_fsm_param_pkg.sv
// Shared types for the parametrised vending controller: coin codes, FSM states
// and the coin-code-to-value mapping used by both the controller and change selector.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_2    = 2'b10,
    COIN_5    = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CREDIT = 2'b01,
    VEND   = 2'b10,
    CHANGE = 2'b11
  } state_e;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      2'b11:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_fsm_param_if.sv
// Customer-side bundle of the vending controller: coin/purchase/cancel inputs,
// change handshake and status outputs.
interface vending_fsm_param_if #(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 6
);

  logic [1:0]          moneda;
  logic [N_PROD-1:0]   comprar;
  logic                cancelar;
  logic                cambio_ack;
  logic [N_PROD-1:0]   listo;
  logic [CREDIT_W-1:0] total;
  logic [N_PROD-1:0]   vend;
  logic                cambio_valid;
  logic [1:0]          cambio_coin;
  logic                moneda_rech;
  logic                busy;

  modport master (
    output moneda, comprar, cancelar, cambio_ack,
    input  listo, total, vend, cambio_valid, cambio_coin, moneda_rech, busy
  );

  modport slave (
    input  moneda, comprar, cancelar, cambio_ack,
    output listo, total, vend, cambio_valid, cambio_coin, moneda_rech, busy
  );

endinterface

// File: rtl/vending_fsm_param_coin_change_sel.sv
// Greedy change selector: for a given credit, the largest coin (5, 2, 1) that
// does not exceed it, plus that coin's value. Purely combinational.
module coin_change_sel
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] i_total,
  output coin_e               o_coin,
  output logic [2:0]          o_value
);

  // Widened so the constant 5 is representable even for very narrow credit widths.
  logic [CREDIT_W+2:0] w_total_ext;
  assign w_total_ext = {3'b000, i_total};

  always_comb begin
    o_coin  = COIN_NONE;
    o_value = 3'd0;
    if (w_total_ext >= (CREDIT_W+3)'(5)) begin
      o_coin  = COIN_5;
      o_value = coin_value(COIN_5);
    end else if (w_total_ext >= (CREDIT_W+3)'(2)) begin
      o_coin  = COIN_2;
      o_value = coin_value(COIN_2);
    end else if (w_total_ext >= (CREDIT_W+3)'(1)) begin
      o_coin  = COIN_1;
      o_value = coin_value(COIN_1);
    end
  end

endmodule

// File: rtl/vending_fsm_param.sv
// N-product vending controller: accumulates coin credit, vends the lowest-index
// affordable request, and returns change or refunds coin by coin over valid/ack.
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int                         N_PROD     = 4,
  parameter int                         CREDIT_W   = 6,
  parameter int                         MAX_CREDIT = 31,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {6'd10, 6'd7, 6'd5, 6'd3}
) (
  input logic               clk,
  input logic               reset,
  vending_fsm_param_if.slave bus
);

  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  if (N_PROD < 1 || N_PROD > 8) begin : g_bad_nprod
    $error("vending_fsm_param: N_PROD must be in 1..8");
  end
  if (MAX_CREDIT < 1 || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max
    $error("vending_fsm_param: MAX_CREDIT must be below 2**CREDIT_W");
  end

  state_e              r_state;
  logic [CREDIT_W-1:0] r_total;
  logic [SEL_W-1:0]    r_sel;
  logic [N_PROD-1:0]   r_listo;
  logic [N_PROD-1:0]   r_vend;
  logic                r_cambio_valid;
  coin_e               r_cambio_coin;
  logic                r_moneda_rech;
  logic                r_busy;

  state_e              w_state_next;
  logic [CREDIT_W-1:0] w_total_next;
  logic [SEL_W-1:0]    w_sel_next;
  logic                w_rech_next;
  logic                w_open_next;
  logic [N_PROD-1:0]   w_listo_next;
  logic [N_PROD-1:0]   w_vend_onehot;
  logic [CREDIT_W-1:0] w_price [N_PROD];
  logic                w_req_any;
  logic [SEL_W-1:0]    w_req_idx;
  logic                w_coin_in;
  logic [CREDIT_W:0]   w_sum;
  coin_e               w_chg_coin_cur;
  logic [2:0]          w_chg_val_cur;
  coin_e               w_chg_coin_next;
  logic [2:0]          w_chg_val_next;

  assign w_open_next = (w_state_next == IDLE) || (w_state_next == CREDIT);

  for (genvar gi = 0; gi < N_PROD; gi++) begin : g_prod
    assign w_price[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
    if (int'(PRICES[gi*CREDIT_W +: CREDIT_W]) < 1 ||
        int'(PRICES[gi*CREDIT_W +: CREDIT_W]) > MAX_CREDIT) begin : g_bad_price
      $error("vending_fsm_param: every price must be in 1..MAX_CREDIT");
    end
    assign w_listo_next[gi] = w_open_next && (w_total_next >= w_price[gi]);
  end

  // Lowest set request bit wins.
  always_comb begin
    w_req_any = 1'b0;
    w_req_idx = '0;
    for (int k = N_PROD - 1; k >= 0; k--) begin
      if (bus.comprar[k]) begin
        w_req_any = 1'b1;
        w_req_idx = SEL_W'(k);
      end
    end
  end

  assign w_coin_in = (bus.moneda != COIN_NONE);
  assign w_sum     = {1'b0, r_total} + (CREDIT_W+1)'(coin_value(bus.moneda));

  // Current total drives the ack subtraction; next total drives the registered coin output.
  coin_change_sel #(.CREDIT_W(CREDIT_W)) u_sel_cur (
    .i_total (r_total),
    .o_coin  (w_chg_coin_cur),
    .o_value (w_chg_val_cur)
  );

  coin_change_sel #(.CREDIT_W(CREDIT_W)) u_sel_next (
    .i_total (w_total_next),
    .o_coin  (w_chg_coin_next),
    .o_value (w_chg_val_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_total_next = r_total;
    w_sel_next   = r_sel;
    w_rech_next  = 1'b0;
    case (r_state)
      IDLE, CREDIT: begin
        if (bus.cancelar && (r_total != '0)) begin
          w_state_next = CHANGE;
          w_rech_next  = w_coin_in;
        end else if (w_req_any && (r_total >= w_price[w_req_idx])) begin
          w_state_next = VEND;
          w_sel_next   = w_req_idx;
          w_rech_next  = w_coin_in;
        end else if (w_coin_in) begin
          if (w_sum <= MAX_SUM) begin
            w_total_next = w_sum[CREDIT_W-1:0];
            w_state_next = CREDIT;
          end else begin
            w_rech_next = 1'b1;
          end
        end
      end
      VEND: begin
        w_rech_next  = w_coin_in;
        w_total_next = r_total - w_price[r_sel];
        w_state_next = (w_total_next != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_rech_next = w_coin_in;
        if (w_chg_coin_cur == COIN_NONE) begin
          w_state_next = IDLE;
        end else if (bus.cambio_ack) begin
          w_total_next = r_total - CREDIT_W'(w_chg_val_cur);
          if (w_total_next == '0) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_vend_onehot = N_PROD'(1) << w_sel_next;

  // Outputs are registered from the next state/total so they line up with r_state/r_total.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_total        <= '0;
      r_sel          <= '0;
      r_listo        <= '0;
      r_vend         <= '0;
      r_cambio_valid <= 1'b0;
      r_cambio_coin  <= COIN_NONE;
      r_moneda_rech  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_total        <= w_total_next;
      r_sel          <= w_sel_next;
      r_listo        <= w_listo_next;
      r_vend         <= (w_state_next == VEND) ? w_vend_onehot : '0;
      r_cambio_valid <= (w_state_next == CHANGE) && (w_chg_val_next != 3'd0);
      r_cambio_coin  <= (w_state_next == CHANGE) ? w_chg_coin_next : COIN_NONE;
      r_moneda_rech  <= w_rech_next;
      r_busy         <= (w_state_next == VEND) || (w_state_next == CHANGE);
    end
  end

  assign bus.listo        = r_listo;
  assign bus.total        = r_total;
  assign bus.vend         = r_vend;
  assign bus.cambio_valid = r_cambio_valid;
  assign bus.cambio_coin  = r_cambio_coin;
  assign bus.moneda_rech  = r_moneda_rech;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Randomised and directed check of vending_fsm_param against a queue-based
// model: credit as a number, pending change as a list of coins still owed.
module tb_vending_fsm_param;

  logic clk;
  logic reset;

  vending_fsm_param_if #(.N_PROD(4), .CREDIT_W(6)) bus ();

  vending_fsm_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  int price [4] = '{3, 5, 7, 10};
  int credit;
  int pend;
  int chg_q [$];
  int e_vend;
  int e_rech;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int val_of(input logic [1:0] m);
    case (m)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int code_of(input int v);
    if (v == 5) return 3;
    if (v == 2) return 2;
    if (v == 1) return 1;
    return 0;
  endfunction

  task automatic fill_q(input int amount);
    int rem;
    rem = amount;
    chg_q.delete();
    while (rem > 0) begin
      if (rem >= 5) begin chg_q.push_back(5); rem -= 5; end
      else if (rem >= 2) begin chg_q.push_back(2); rem -= 2; end
      else begin chg_q.push_back(1); rem -= 1; end
    end
  endtask

  task automatic model_step(input logic [1:0] m, input logic [3:0] c, input logic cn,
                            input logic a, input logic rst);
    int lo;
    int cv;
    int dummy;
    cv = val_of(m);
    e_vend = 0;
    e_rech = 0;
    lo = -1;
    for (int k = 3; k >= 0; k--) if (c[k]) lo = k;
    if (rst) begin
      credit = 0;
      pend   = -1;
      chg_q.delete();
    end else if (pend >= 0) begin
      e_rech = (m != 0);
      fill_q(credit - price[pend]);
      credit = 0;
      pend   = -1;
    end else if (chg_q.size() > 0) begin
      e_rech = (m != 0);
      if (a) dummy = chg_q.pop_front();
    end else if (cn && credit > 0) begin
      fill_q(credit);
      credit = 0;
      e_rech = (m != 0);
    end else if (lo >= 0 && credit >= price[lo]) begin
      pend   = lo;
      e_vend = 1 << lo;
      e_rech = (m != 0);
    end else if (m != 0) begin
      if (credit + cv <= 31) credit += cv;
      else e_rech = 1;
    end
  endtask

  task automatic compare_all();
    int tot;
    int lst;
    bit open;
    tot = credit;
    if (chg_q.size() > 0) begin
      tot = 0;
      foreach (chg_q[k]) tot += chg_q[k];
    end
    open = (pend < 0) && (chg_q.size() == 0);
    lst = 0;
    for (int k = 0; k < 4; k++) if (open && credit >= price[k]) lst |= (1 << k);
    chk("total", 32'(bus.total), 32'(tot));
    chk("listo", 32'(bus.listo), 32'(lst));
    chk("vend", 32'(bus.vend), 32'(e_vend));
    chk("cambio_valid", 32'(bus.cambio_valid), 32'(chg_q.size() > 0));
    chk("cambio_coin", 32'(bus.cambio_coin), 32'((chg_q.size() > 0) ? code_of(chg_q[0]) : 0));
    chk("moneda_rech", 32'(bus.moneda_rech), 32'(e_rech));
    chk("busy", 32'(bus.busy), 32'((pend >= 0) || (chg_q.size() > 0)));
  endtask

  task automatic cyc(input logic [1:0] m, input logic [3:0] c, input logic cn,
                     input logic a, input logic rst);
    @(negedge clk);
    bus.moneda     = m;
    bus.comprar    = c;
    bus.cancelar   = cn;
    bus.cambio_ack = a;
    reset          = rst;
    @(posedge clk);
    model_step(m, c, cn, a, rst);
    #1;
    compare_all();
    $display("cyc t=%0t m=%0d c=%b cn=%0d a=%0d rst=%0d -> total=%0d vend=%b cv=%0d coin=%0d rech=%0d",
             $time, m, c, cn, a, rst, bus.total, bus.vend, bus.cambio_valid,
             bus.cambio_coin, bus.moneda_rech);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((bus.busy || bus.cambio_valid) && budget < 20) begin
      cyc(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
      budget++;
    end
    chk("drain_done", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    credit = 0;
    pend   = -1;
    bus.moneda = 2'b00; bus.comprar = '0; bus.cancelar = 1'b0; bus.cambio_ack = 1'b0;
    reset = 1'b1;
    cyc(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("reset_total", 32'(bus.total), 32'(0));

    // 2 + 1, buy product 0 (price 3): exact, no change
    cyc(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 4'b0001, 1'b0, 1'b0, 1'b0);
    chk("tp1_vend", 32'(bus.vend), 32'(1));
    cyc(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("tp1_total", 32'(bus.total), 32'(0));
    chk("tp1_busy", 32'(bus.busy), 32'(0));

    // 5 + 5, buy product 1 (price 5): one 5 back
    cyc(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 4'b0010, 1'b0, 1'b0, 1'b0);
    chk("tp2_vend", 32'(bus.vend), 32'(2));
    cyc(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("tp2_coin", 32'(bus.cambio_coin), 32'(3));
    cyc(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("tp2_valid", 32'(bus.cambio_valid), 32'(0));

    // 5 + 2, cancel, ack each cycle: 5 then 2; ack held low 3 cycles first
    cyc(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("tp4_hold_coin", 32'(bus.cambio_coin), 32'(3));
      chk("tp4_hold_total", 32'(bus.total), 32'(7));
    end
    cyc(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("tp3_coin2", 32'(bus.cambio_coin), 32'(2));
    cyc(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("tp3_idle", 32'(bus.busy), 32'(0));

    // saturate at 30, reject 2, accept 1
    for (int k = 0; k < 6; k++) cyc(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("tp5_rech", 32'(bus.moneda_rech), 32'(1));
    chk("tp5_total30", 32'(bus.total), 32'(30));
    cyc(2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("tp5_total31", 32'(bus.total), 32'(31));
    cyc(2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    drain();

    // total 3, request 0110 plus coin 5: request ignored, coin taken
    cyc(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 4'b0110, 1'b0, 1'b0, 1'b0);
    chk("tp6_total", 32'(bus.total), 32'(8));
    chk("tp6_vend", 32'(bus.vend), 32'(0));

    // reset during CHANGE
    cyc(2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("tp7_inchange", 32'(bus.cambio_valid), 32'(1));
    cyc(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("tp7_total", 32'(bus.total), 32'(0));
    chk("tp7_busy", 32'(bus.busy), 32'(0));

    for (int n = 0; n < 3000; n++) begin
      logic [1:0] m;
      logic [3:0] c;
      logic cn, a, rst;
      m   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      c   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cn  = ($urandom_range(0, 14) == 0);
      a   = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      cyc(m, c, cn, a, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vending_fsm_param.md
# vending_fsm_param

Parametrised next-generation vending controller. It supports N products with per-product prices, accumulates credit from coded coins, and vends on request. It returns change or a full refund coin by coin over a valid/ack handshake. It slots into the top-level wrapper in place of the fixed two-product Moore/Mealy pair and drives the same ready/total indications.

## Interface
Parameters:
- N_PROD, 4: number of products (1..8).
- CREDIT_W, 6: width of the credit register.
- MAX_CREDIT, 31: maximum credit held. Must be < 2**CREDIT_W; elaboration error otherwise.
- PRICES, {6'd10,6'd7,6'd5,6'd3}: packed prices. Product i price = PRICES[i*CREDIT_W +: CREDIT_W]. Every price must be in 1..MAX_CREDIT; elaboration error otherwise.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- moneda  in  2  coin code, one cycle per coin: 00 none, 01 = 1, 10 = 2, 11 = 5 units.
- comprar  in  N_PROD  purchase request per product; lowest set index wins.
- cancelar  in  1  refund request.
- cambio_ack  in  1  change coin taken.
- listo  out  N_PROD  bit i = total >= price i, in IDLE/CREDIT only.
- total  out  CREDIT_W  current credit (registered).
- vend  out  N_PROD  one-cycle dispense pulse.
- cambio_valid  out  1  change coin presented.
- cambio_coin  out  2  coin code being returned (same encoding as moneda).
- moneda_rech  out  1  one-cycle pulse: coin rejected.
- busy  out  1  state is VEND or CHANGE.

## Operation
- States:
  - IDLE: total == 0.
  - CREDIT: total > 0.
  - VEND: one cycle, selected product latched.
  - CHANGE: dispensing total.
- Event priority in IDLE/CREDIT, evaluated on the registered total:
  - cancelar beats comprar, which beats moneda.
  - cancelar with total > 0: go to CHANGE; the whole total is refunded. With total == 0: ignored.
  - comprar: select lowest index i. If total >= price i, go to VEND; otherwise ignore the request.
  - moneda != 00 with no accepted cancel/purchase: if total + value <= MAX_CREDIT, add the value; otherwise reject it (moneda_rech).
  - A coin arriving in the same cycle as an accepted cancel or purchase is rejected (moneda_rech).
- VEND: vend[i] = 1. At the end of the cycle, total <= total - price i. Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE:
  - cambio_valid = 1.
  - cambio_coin = largest denomination <= total (5, then 2, then 1).
  - Each cambio_ack subtracts that coin's value. When total reaches 0, go to IDLE.
  - Coins in VEND/CHANGE are rejected. comprar and cancelar are ignored.
- cambio_ack while cambio_valid = 0 is ignored.
- Arithmetic: coin add is computed at CREDIT_W+1 bits for the overflow compare. Subtractions never underflow, by construction.
- listo is 0 and vend is 0 outside IDLE/CREDIT and VEND respectively.

## Timing
- Reset (synchronous, takes effect at the edge):
  - state IDLE, total 0.
  - listo, vend, cambio_valid, cambio_coin, moneda_rech, busy all 0.
- Reset mid-operation (VEND/CHANGE) aborts immediately; pending change is discarded.
- Coin in cycle n: total updated in n+1; moneda_rech (if rejected) high in n+1.
- Purchase in cycle n:
  - n+1: state VEND, vend[i] high, total unchanged.
  - n+2: total reduced; state CHANGE or IDLE.
- Cancel in cycle n: state CHANGE and cambio_valid high in n+1.
- CHANGE, ack in cycle n: total reduced and cambio_coin recomputed in n+1. cambio_valid drops in n+1 if total becomes 0.
- listo, busy, cambio_valid and cambio_coin are Moore outputs decoded from registered state/total; no input-to-output combinational path.

## Structure
- Shared package vending_pkg holds:
  - coin code enum: COIN_NONE, COIN_1, COIN_2, COIN_5.
  - state enum: IDLE, CREDIT, VEND, CHANGE.
  - function coin_value(code).
- One sub-module, coin_change_sel: combinational; total in, largest returnable coin code and its value out.

## Test plan
- Insert 2 then 1 (total 3), comprar[0]: vend[0] pulses one cycle, total -> 0, no change, back to IDLE.
- Insert 5, 5 (total 10), comprar[1] (price 5): vend[1], then CHANGE with cambio_coin = 5. One ack returns 5; total 0, IDLE.
- Insert 5, 2 (total 7), cancelar, ack every cycle: change sequence 5, 2, then IDLE.
- Hold ack low for 3 cycles in CHANGE: cambio_valid and cambio_coin stay stable and total is unchanged.
- Total 30, insert 2: moneda_rech pulse, total stays 30. Then insert 1: total 31.
- Total 3, comprar = 4'b0110 with coin 5 in the same cycle: product 1 unaffordable, product 2 not chosen. Coin accepted, total 8, no vend.
- Bonus: reset asserted during CHANGE gives total 0 and IDLE next cycle.
